// File: rtl/mtr_drv_np.sv
// mtr_drv_np: N-phase motor driver.
// A free-running PWM with a shadowed duty register feeds a per-phase select
// decoder. A dead-time unit per leg then guarantees a both-off gap around
// every gate change. A latched over-current fault forces all gates off.
// The high and low gates of a leg are never driven together.
module mtr_drv_np #(
    parameter int PHASES = 3,
    parameter int PWM_W  = 11,
    parameter int DT_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PWM_W-1:0]      duty,
    input  logic [2*PHASES-1:0]   sel,
    input  logic [DT_W-1:0]       dead_time,
    input  logic                  ovr_i,
    input  logic                  clr_fault,
    output logic                  PWM_synch,
    output logic [PHASES-1:0]     high,
    output logic [PHASES-1:0]     low,
    output logic                  fault
);

    localparam logic [PWM_W-1:0] PWM_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
    localparam logic [PWM_W-1:0] PWM_LAST = {PWM_W{1'b1}};
    localparam logic [DT_W-1:0]  DT_ONE   = {{(DT_W-1){1'b0}}, 1'b1};
    localparam logic [DT_W-1:0]  DT_ZERO  = {DT_W{1'b0}};

    // Maps a 2-bit drive select and the PWM level to the {hi, lo} pre pair.
    function automatic logic [1:0] decode_sel(input logic [1:0] s, input logic pwm);
        logic [1:0] pair;
        case (s)
            2'b00:   pair = 2'b00;               // coast
            2'b01:   pair = {~pwm, pwm};         // forward
            2'b10:   pair = {pwm, ~pwm};         // reverse
            2'b11:   pair = {1'b0, pwm};         // brake
            default: pair = 2'b00;
        endcase
        return pair;
    endfunction

    logic [PWM_W-1:0]             cnt_r;
    logic [PWM_W-1:0]             duty_q_r;
    logic                         pwm_sig_r;
    logic                         pwm_synch_s;
    logic [PHASES-1:0][1:0]       pre_s;
    logic [PHASES-1:0][1:0]       pre_q_r;
    logic [PHASES-1:0][DT_W-1:0]  dt_cnt_r;
    logic [PHASES-1:0][DT_W-1:0]  dt_nxt_s;
    logic [PHASES-1:0][1:0]       leg_s;
    logic                         fault_nxt_s;
    logic [PHASES-1:0]            high_nxt_s;
    logic [PHASES-1:0]            low_nxt_s;
    logic [PHASES-1:0]            high_r;
    logic [PHASES-1:0]            low_r;
    logic                         fault_r;

    // Period marker on the last count of each PWM period.
    always_comb begin
        pwm_synch_s = (cnt_r == PWM_LAST);
    end

    // PWM counter, duty shadow register (loaded at period end) and PWM level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {PWM_W{1'b0}};
            duty_q_r  <= {PWM_W{1'b0}};
            pwm_sig_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_r + PWM_ONE;
            pwm_sig_r <= (cnt_r < duty_q_r);
            if (pwm_synch_s) begin
                duty_q_r <= duty;
            end else begin
                duty_q_r <= duty_q_r;
            end
        end
    end

    // Per-phase decode, then the dead-time decision for each leg.
    // A change of the pre pair (re)loads the gap counter, so a change
    // arriving mid-gap restarts the gap; the leg only follows pre_q once
    // the pair has been stable and the counter has drained.
    always_comb begin
        pre_s    = '{default: 2'b00};
        dt_nxt_s = dt_cnt_r;
        leg_s    = '{default: 2'b00};
        for (int p = 0; p < PHASES; p++) begin
            pre_s[p] = decode_sel(sel[2*p +: 2], pwm_sig_r);
            if (pre_s[p] != pre_q_r[p]) begin
                dt_nxt_s[p] = dead_time;
                leg_s[p]    = 2'b00;
            end else if (dt_cnt_r[p] != DT_ZERO) begin
                dt_nxt_s[p] = dt_cnt_r[p] - DT_ONE;
                leg_s[p]    = 2'b00;
            end else begin
                dt_nxt_s[p] = dt_cnt_r[p];
                leg_s[p]    = pre_q_r[p];
            end
        end
    end

    // Fault latch next state: over-current wins over a clear request.
    always_comb begin
        if (ovr_i) begin
            fault_nxt_s = 1'b1;
        end else if (clr_fault) begin
            fault_nxt_s = 1'b0;
        end else begin
            fault_nxt_s = fault_r;
        end
    end

    // Gate next values: the dead-time result, blanked while the fault holds.
    always_comb begin
        high_nxt_s = {PHASES{1'b0}};
        low_nxt_s  = {PHASES{1'b0}};
        for (int p = 0; p < PHASES; p++) begin
            if (fault_nxt_s) begin
                high_nxt_s[p] = 1'b0;
                low_nxt_s[p]  = 1'b0;
            end else begin
                high_nxt_s[p] = leg_s[p][1];
                low_nxt_s[p]  = leg_s[p][0];
            end
        end
    end

    // Dead-time state; keeps running while the fault blanks the gates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q_r  <= '{default: 2'b00};
            dt_cnt_r <= '{default: DT_ZERO};
        end else begin
            pre_q_r  <= pre_s;
            dt_cnt_r <= dt_nxt_s;
        end
    end

    // Registered gate drives and fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_r  <= {PHASES{1'b0}};
            low_r   <= {PHASES{1'b0}};
            fault_r <= 1'b0;
        end else begin
            high_r  <= high_nxt_s;
            low_r   <= low_nxt_s;
            fault_r <= fault_nxt_s;
        end
    end

    assign PWM_synch = pwm_synch_s;
    assign high      = high_r;
    assign low       = low_r;
    assign fault     = fault_r;

endmodule

// File: doc/mtr_drv_np.md
# mtr_drv_np

Parametrised N-phase motor driver with a free-running PWM, duty shadowing, per-leg programmable dead time and a latched over-current shutdown. It sits between the commutation/control logic and the gate-driver pins, and is the generalisation of the fixed three-coil 11-bit driver. Each phase takes a 2-bit drive select and produces a high-side/low-side gate pair. The pair is guaranteed never to be high together, and every change of state passes through a both-off gap.

## Interface

Parameters:
- PHASES, 3, number of half-bridge legs
- PWM_W, 11, PWM counter/duty width; period = 2^PWM_W clocks
- DT_W, 5, dead-time counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- duty  in  PWM_W  requested duty in clocks per period
- sel  in  2*PHASES  per-phase select; phase p uses sel[2p+1:2p]
- dead_time  in  DT_W  dead-time gap length minus one, in clocks
- ovr_i  in  1  over-current fault, already synchronous to clk
- clr_fault  in  1  single-cycle fault clear request
- PWM_synch  out  1  one-clock pulse on the last cycle of each PWM period
- high  out  PHASES  high-side gate drives
- low  out  PHASES  low-side gate drives
- fault  out  1  latched over-current indication

## Operation

- One clock domain is used throughout. All state resets asynchronously when rst_n is low.
- Reset values:
  - cnt = 0, duty_q = 0, PWM_sig = 0, PWM_synch = 0.
  - fault = 0.
  - high = 0 and low = 0 for all phases.
  - All dead-time counters = 0 and all pre_q = 00.
- PWM generation:
  - cnt (PWM_W bits) increments every clock and wraps from 2^PWM_W-1 to 0.
  - PWM_synch = (cnt == 2^PWM_W-1), combinational from cnt.
  - duty_q is loaded from duty only on the clock edge that ends the PWM_synch cycle. A duty change mid-period never affects the current period.
  - PWM_sig is registered: PWM_sig <= (cnt < duty_q). Its high time is exactly duty_q clocks per period.
  - duty = 0 gives PWM_sig constantly 0. duty = 2^PWM_W-1 gives a single low clock per period.
- Per-phase decode of sel into the pre pair {hi_pre, lo_pre}:
  - 00 coast: {0, 0}.
  - 01 forward: {~PWM_sig, PWM_sig}.
  - 10 reverse: {PWM_sig, ~PWM_sig}.
  - 11 brake: {0, PWM_sig}.
- Per-leg dead-time unit; each phase is independent:
  - Register pre_q <= pre every cycle.
  - If pre != pre_q: load dt_cnt <= dead_time and drive both outputs 0.
  - Else if dt_cnt != 0: decrement dt_cnt and hold both outputs 0.
  - Else: outputs <= pre_q.
  - A change that occurs during a gap reloads dt_cnt, so the gap restarts.
  - dead_time is sampled only at the change.
- Fault handling:
  - ovr_i = 1 sets fault at the next edge.
  - While fault = 1, all high and low outputs are forced 0 (registered, same edge as fault sets). Dead-time counters and pre_q keep running.
  - clr_fault clears fault only if ovr_i = 0 in the same cycle; otherwise clr_fault is ignored.
  - If ovr_i and clr_fault are high together, fault stays set.
  - After a clear, outputs resume from the dead-time unit's state on the next edge. No extra gap is added.
- Invariant: high[p] & low[p] is never 1, in any cycle, for any p.

## Timing

- PWM period is 2^PWM_W clocks, and PWM_synch occurs once per period.
- First PWM_synch after reset is in the cycle with cnt = 2^PWM_W-1, which is clock 2^PWM_W-1 after reset release.
- Duty latency: a new duty takes effect in the cycle where cnt = 0, one clock after the PWM_synch edge that loads it; PWM_sig reflects it one clock later.
- Leg transition, for a pre change visible in cycle k:
  - Outputs are 0 from edge k+1.
  - The new value appears at edge k+dead_time+2.
  - The both-off gap is therefore dead_time+1 clocks; dead_time = 0 still gives a 1-clock gap.
- Outputs that hold no change follow pre_q with one-clock latency from pre.
- Fault:
  - Outputs are 0 one edge after ovr_i is seen high, and stay 0 while fault = 1.
  - fault clears one edge after a valid clr_fault.
- Reset mid-operation: all outputs go 0 immediately (asynchronously). The PWM restarts from cnt = 0 with duty_q = 0.

## Test plan

- Bench configuration: PWM_W = 4, DT_W = 3, PHASES = 3 (period 16).
- Duty shadowing: duty = 5 held, then change to 12 at cnt = 3 → the current period shows 5 high clocks and the next period shows 12. PWM_synch pulses every 16 clocks.
- Extremes: duty = 0 → PWM_sig is never high. duty = 15 → exactly 1 low clock per period. All sel = 01 → high is never 1 when duty = 15 except the inverted clocks.
- Dead time: sel[1:0] = 01, dead_time = 3, duty = 8 → every high/low edge on phase 0 is separated by exactly 4 both-low clocks. With dead_time = 0 the gap is 1 clock.
- Select modes: sel = {11, 10, 00} → phase 2 high stays 0 and low follows PWM_sig; phase 1 is complementary-reversed; phase 0 stays 0/0. high & low is never 1 on any phase across the whole run.
- Fault: assert ovr_i for 1 clock mid-period → all outputs 0 next edge and fault = 1. clr_fault with ovr_i = 1 → fault stays 1. clr_fault with ovr_i = 0 → fault = 0 next edge and outputs resume.
- Reset mid-period: pull rst_n low at cnt = 9 with duty_q = 10 → all outputs and PWM_synch are 0 immediately. After release, the first PWM_synch comes after 15 clocks and PWM_sig stays 0 until the new duty loads.
